// File: rtl/ethernet_rx_frame_filter.sv
// Store-and-forward RX frame filter: forwards only complete, clean, in-size frames; first beat 2 cycles after tlast.
// Never backpressures the MAC (s_tready=1 out of reset); overflow, oversize and errored frames are dropped.
module ethernet_rx_frame_filter #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 11,
  parameter int MAX_FRAME_LENGTH = 1518
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_good,
  output logic                  frame_drop,
  output logic [1:0]            drop_reason,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LW    = $clog2(MAX_FRAME_LENGTH + 1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_FRAME_LENGTH);
  localparam logic [1:0] RSN_ERR = 2'b01;
  localparam logic [1:0] RSN_BIG = 2'b10;
  localparam logic [1:0] RSN_OVF = 2'b11;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  typedef enum logic {WR_ACTIVE, WR_DROP} wr_state_t;

  wr_state_t       state, state_nxt;
  logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]   wr_commit, wr_commit_nxt;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   len, len_nxt;
  logic            err, err_nxt;
  logic            good_nxt, drop_nxt;
  logic [1:0]      reason_nxt;
  logic            mem_we;
  logic            beat;
  logic            full;
  logic            load;
  entry_t          wr_entry, rd_entry;
  entry_t          mem [DEPTH];

  assign beat     = s_tvalid & s_tready;
  // Registered rd_ptr only: a slot freed this cycle is not yet counted as free.
  assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
  assign wr_entry = '{last: s_tlast, dat: s_tdata};
  assign rd_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign load     = (rd_ptr != wr_commit) && (!m_tvalid || m_tready);

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    len_nxt       = len;
    err_nxt       = err;
    mem_we        = 1'b0;
    good_nxt      = 1'b0;
    drop_nxt      = 1'b0;
    reason_nxt    = 2'b00;
    case (state)
      WR_ACTIVE: begin
        if (beat) begin
          if (full || len == MAX_LEN) begin
            wr_ptr_nxt = wr_commit;
            drop_nxt   = 1'b1;
            reason_nxt = full ? RSN_OVF : RSN_BIG;
            len_nxt    = '0;
            err_nxt    = 1'b0;
            if (!s_tlast) state_nxt = WR_DROP;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            len_nxt    = len + 1'b1;
            err_nxt    = err | s_tuser;
            if (s_tlast) begin
              if (err | s_tuser) begin
                wr_ptr_nxt = wr_commit;
                drop_nxt   = 1'b1;
                reason_nxt = RSN_ERR;
              end else begin
                wr_commit_nxt = wr_ptr + 1'b1;
                good_nxt      = 1'b1;
              end
              len_nxt = '0;
              err_nxt = 1'b0;
            end
          end
        end
      end
      WR_DROP: begin
        if (beat && s_tlast) begin
          len_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = WR_ACTIVE;
        end
      end
      default: state_nxt = WR_ACTIVE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (mem_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_entry;
  end

  always_ff @(posedge rx_clk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      state       <= WR_ACTIVE;
      wr_ptr      <= '0;
      wr_commit   <= '0;
      len         <= '0;
      err         <= 1'b0;
      s_tready    <= 1'b0;
      frame_good  <= 1'b0;
      frame_drop  <= 1'b0;
      drop_reason <= 2'b00;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      wr_commit   <= wr_commit_nxt;
      len         <= len_nxt;
      err         <= err_nxt;
      s_tready    <= 1'b1;
      frame_good  <= good_nxt;
      frame_drop  <= drop_nxt;
      drop_reason <= reason_nxt;
      if (drop_nxt && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      rd_ptr   <= rd_ptr + 1'b1;
      m_tvalid <= 1'b1;
      m_tdata  <= rd_entry.dat;
      m_tlast  <= rd_entry.last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule
